mulu_x6y6_seq: RTL and testbench

MULU_X6Y6_SEQ -- requirements
Module: mulu_x6y6_seq

---
 rtl/mulu_seq_pkg.sv | 33 +++
 rtl/mulu_x3y3.sv | 25 ++
 rtl/mulu_x6y6_seq.sv | 116 +++++++++++
 tb/tb_mulu_x6y6_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mulu_seq_pkg.sv
// Shared constants and helpers for the sequential 6x6 unsigned multiplier:
// controller state encoding, partial-product step count and per-step shifts.
package mulu_seq_pkg;

  localparam int HALF_W_DEF = 3;
  localparam int NUM_STEPS  = 4;
  localparam int STEP_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mulu_state_e;

  // Step order: xl*yl, xl*yh, xh*yl, xh*yh -> bit1 picks the x half, bit0 the y half.
  function automatic logic step_x_high(input logic [STEP_W-1:0] step);
    return step[1];
  endfunction

  function automatic logic step_y_high(input logic [STEP_W-1:0] step);
    return step[0];
  endfunction

  function automatic int step_shift(input logic [STEP_W-1:0] step, input int half_w);
    case (step)
      2'd0:    return 0;
      2'd1:    return half_w;
      2'd2:    return half_w;
      default: return 2 * half_w;
    endcase
  endfunction

endpackage

// File: rtl/mulu_x3y3.sv
// Combinational unsigned X_WIDTH x Y_WIDTH multiplier core, shared by the
// sequential controller. Optional sign/ready outputs exist for other users.
module mulu_x3y3 #(
  parameter int X_WIDTH   = 3,
  parameter int Y_WIDTH   = 3,
  parameter bit HAS_SIGN  = 1'b0,
  parameter bit HAS_READY = 1'b0
) (
  input  logic [X_WIDTH-1:0]         x_i,
  input  logic [Y_WIDTH-1:0]         y_i,
  output logic [X_WIDTH+Y_WIDTH-1:0] p_o,
  output logic                       sign_o,
  output logic                       ready_o
);

  localparam int P_WIDTH = X_WIDTH + Y_WIDTH;

  assign p_o = P_WIDTH'(x_i) * P_WIDTH'(y_i);

  // Unsigned operands never give a negative product; the core is purely
  // combinational so it is always ready when that output is enabled.
  assign sign_o  = HAS_SIGN & 1'b0;
  assign ready_o = HAS_READY;

endmodule

// File: rtl/mulu_x6y6_seq.sv
// Sequential 2*HALF_W x 2*HALF_W unsigned multiplier: four partial products
// through one shared HALF_W x HALF_W core, valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised, stays high with stable data until that transfer.
module mulu_x6y6_seq
  import mulu_seq_pkg::*;
#(
  parameter int HALF_W     = HALF_W_DEF,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_x,
  input  logic [2*HALF_W-1:0]   in_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   out_p,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int OP_W  = 2 * HALF_W;
  localparam int PP_W  = 2 * HALF_W;
  localparam int ACC_W = 4 * HALF_W;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  mulu_state_e         state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [OP_W-1:0]     x_q, x_d;
  logic [OP_W-1:0]     y_q, y_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  logic                accept;
  logic                zero_op;
  logic [HALF_W-1:0]   mul_x, mul_y;
  logic [PP_W-1:0]     pp;
  logic [ACC_W-1:0]    pp_shifted;

  mulu_x3y3 #(
    .X_WIDTH   (HALF_W),
    .Y_WIDTH   (HALF_W),
    .HAS_SIGN  (1'b0),
    .HAS_READY (1'b0)
  ) u_mul (
    .x_i     (mul_x),
    .y_i     (mul_y),
    .p_o     (pp),
    .sign_o  (),
    .ready_o ()
  );

  assign accept     = in_valid && in_ready;
  assign zero_op    = (in_x == '0) || (in_y == '0);
  assign pp_shifted = ACC_W'(pp) << step_shift(step_q, HALF_W);

  // State register plus operand/accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

  // Next state. An accept overrides everything, which also covers the
  // back-to-back case of a DONE handshake and a new operand on one edge.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_MUL: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      x_d     = in_x;
      y_d     = in_y;
      acc_d   = '0;
      step_d  = '0;
      state_d = (EARLY_ZERO && zero_op) ? ST_DONE : ST_MUL;
    end
  end

  // Outputs and the step-driven operand mux into the shared core.
  always_comb begin
    in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_MUL);
    out_p     = acc_q;
    dbg_state = state_q;
    mul_x     = step_x_high(step_q) ? x_q[OP_W-1:HALF_W] : x_q[HALF_W-1:0];
    mul_y     = step_y_high(step_q) ? y_q[OP_W-1:HALF_W] : y_q[HALF_W-1:0];
  end

endmodule

// File: tb/tb_mulu_x6y6_seq.sv
// Bench for mulu_x6y6_seq: directed cases plus 1000 random operand pairs,
// scored in order against plain x*y products.
module tb_mulu_x6y6_seq;
  import mulu_seq_pkg::*;

  localparam int HW = HALF_W_DEF;
  localparam int OW = 2 * HW;
  localparam int PW = 4 * HW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [OW-1:0] in_x, in_y;
  logic [PW-1:0] out_p;
  logic [1:0]    dbg_state;

  logic          nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
  logic [OW-1:0] nz_in_x, nz_in_y;
  logic [PW-1:0] nz_out_p;
  logic [1:0]    nz_dbg_state;

  int            checks   = 0;
  int            failures = 0;
  logic [PW-1:0] exp_q[$];
  bit            rdy_random = 1'b0;

  mulu_x6y6_seq #(.HALF_W(HW), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .busy(busy), .dbg_state(dbg_state)
  );

  mulu_x6y6_seq #(.HALF_W(HW), .EARLY_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst(rst),
    .in_valid(nz_in_valid), .in_ready(nz_in_ready), .in_x(nz_in_x), .in_y(nz_in_y),
    .out_valid(nz_out_valid), .out_ready(nz_out_ready), .out_p(nz_out_p),
    .busy(nz_busy), .dbg_state(nz_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] model_product(input logic [OW-1:0] x, input logic [OW-1:0] y);
    return PW'(int'(x) * int'(y));
  endfunction

  // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic send(input logic [OW-1:0] x, input logic [OW-1:0] y);
    int w = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", PW'(0), PW'(1));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model_product(x, y));
    #1;
    in_valid = 1'b0;
  endtask

  // Rising edges after the accept edge until out_valid, and busy cycles seen.
  task automatic measure(output int edges, output int busy_n);
    edges = 0;
    busy_n = 0;
    while (!out_valid && edges < 20) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) check("done_timeout", PW'(0), PW'(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_random) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=none", out_p);
      end else begin
        check("product", out_p, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int edges, busy_n, w;
    logic [OW-1:0] rx, ry;

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    nz_in_valid = 1'b0; nz_in_x = '0; nz_in_y = '0; nz_out_ready = 1'b1;
    #2;
    check("reset_out_valid", PW'(out_valid), PW'(0));
    check("reset_out_p", out_p, PW'(0));
    check("reset_busy", PW'(busy), PW'(0));
    check("reset_in_ready", PW'(in_ready), PW'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("first_edge_ready", PW'(in_ready), PW'(1));

    // Full-scale operands: four partial products, busy for exactly four cycles.
    send(6'd63, 6'd63);
    measure(edges, busy_n);
    check("latency_63x63", PW'(edges), PW'(4));
    check("busy_63x63", PW'(busy_n), PW'(4));
    check("value_63x63", out_p, PW'(3969));

    send(6'd42, 6'd21);
    measure(edges, busy_n);
    check("latency_42x21", PW'(edges), PW'(4));
    send(6'd5, 6'd7);
    measure(edges, busy_n);
    check("value_5x7", out_p, PW'(35));

    // Zero shortcut: valid straight off the accept edge, never busy.
    send(6'd0, 6'd45);
    measure(edges, busy_n);
    check("latency_zero", PW'(edges), PW'(0));
    check("busy_zero", PW'(busy_n), PW'(0));
    check("value_zero", out_p, PW'(0));
    @(posedge clk);
    #1;

    // Shortcut disabled: zero goes through all four steps.
    nz_in_x = '0; nz_in_y = 6'd45; nz_in_valid = 1'b1;
    @(negedge clk);
    check("nz_in_ready", PW'(nz_in_ready), PW'(1));
    @(posedge clk);
    #1;
    nz_in_valid = 1'b0;
    edges = 0;
    while (!nz_out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("nz_latency", PW'(edges), PW'(4));
    check("nz_value", nz_out_p, PW'(0));

    // Backpressure, then a same-edge output handshake and new accept.
    out_ready = 1'b0;
    send(6'd12, 6'd34);
    measure(edges, busy_n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_p", out_p, PW'(408));
      check("stall_in_ready", PW'(in_ready), PW'(0));
      check("stall_out_valid", PW'(out_valid), PW'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_x = 6'd9; in_y = 6'd9; in_valid = 1'b1;
    @(negedge clk);
    check("overlap_in_ready", PW'(in_ready), PW'(1));
    @(posedge clk);
    exp_q.push_back(model_product(6'd9, 6'd9));
    #1;
    in_valid = 1'b0;
    check("overlap_no_idle", PW'(dbg_state), PW'(ST_MUL));
    measure(edges, busy_n);
    check("overlap_latency", PW'(edges), PW'(4));
    check("overlap_value", out_p, PW'(81));

    // Reset during step 2 discards the operation.
    send(6'd63, 6'd63);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_busy", PW'(busy), PW'(1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midreset_out_valid", PW'(out_valid), PW'(0));
    check("midreset_out_p", out_p, PW'(0));
    check("midreset_busy", PW'(busy), PW'(0));
    check("midreset_in_ready", PW'(in_ready), PW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(6'd2, 6'd3);
    measure(edges, busy_n);
    check("post_reset_latency", PW'(edges), PW'(4));
    check("post_reset_value", out_p, PW'(6));
    @(posedge clk);
    #1;

    // Random operand pairs with random consumer stalls.
    rdy_random = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rx = OW'($urandom_range(0, 63));
      ry = OW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) rx = '0;
      if ($urandom_range(0, 9) == 0) ry = '0;
      send(rx, ry);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    rdy_random = 1'b0;
    check("drain_empty", PW'(exp_q.size()), PW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
